// File: rtl/screen_pkg.sv
// screen_pkg: shared state encodings and winner codes for the LED racer screens
package screen_pkg;
    localparam int WIN_W = 3;
    typedef enum logic [1:0] {
        S_MENU = 2'd0,
        S_GAME = 2'd1,
        S_END  = 2'd2
    } state_t;
    typedef enum logic [WIN_W-1:0] {
        W_NONE   = 3'd0,
        W_GREEN  = 3'd1,
        W_RED    = 3'd2,
        W_BLUE   = 3'd3,
        W_YELLOW = 3'd4
    } winner_t;
endpackage

// File: rtl/winner_detect.sv
// winner_detect: flags any finished player and picks the winner, green > red > blue > yellow
module winner_detect
    import screen_pkg::*;
#(
    parameter int MAX_POS = 109,
    localparam int PW = $clog2(MAX_POS)
) (
    input  logic [PW-1:0] red_pos_i,
    input  logic [PW-1:0] blue_pos_i,
    input  logic [PW-1:0] green_pos_i,
    input  logic [PW-1:0] yellow_pos_i,
    output logic          finish_any_o,
    output winner_t       winner_o
);
    localparam logic [PW-1:0] LAST = PW'(MAX_POS - 1);

    always_comb begin
        winner_o     = (green_pos_i  == LAST) ? W_GREEN  :
                       (red_pos_i    == LAST) ? W_RED    :
                       (blue_pos_i   == LAST) ? W_BLUE   :
                       (yellow_pos_i == LAST) ? W_YELLOW : W_NONE;
        finish_any_o = (winner_o != W_NONE);
    end
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: selects menu/game/end screen, switching only on strip frame boundaries
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int MAX_POS         = 109,
    parameter int END_HOLD_FRAMES = 150,
    localparam int PW = $clog2(MAX_POS),
    localparam int CW = $clog2(END_HOLD_FRAMES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_btn,
    input  logic             frame_done,
    input  logic [PW-1:0]    red_pos,
    input  logic [PW-1:0]    blue_pos,
    input  logic [PW-1:0]    green_pos,
    input  logic [PW-1:0]    yellow_pos,
    output logic             menu_en,
    output logic             game_en,
    output logic             end_en,
    output logic [WIN_W-1:0] winner,
    output logic             game_clear
);
    state_t          state_q, state_d, tgt_q, tgt_d, req_tgt;
    winner_t         winner_q, winner_d, det_winner;
    logic            pend_q, pend_d, btn_q, req, finish_any, hold_done;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [2:0]      en_q, en_d;
    logic            clear_q, clear_d;

    winner_detect #(.MAX_POS(MAX_POS)) u_wd (
        .red_pos_i    (red_pos),
        .blue_pos_i   (blue_pos),
        .green_pos_i  (green_pos),
        .yellow_pos_i (yellow_pos),
        .finish_any_o (finish_any),
        .winner_o     (det_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_MENU;
            tgt_q   <= S_MENU;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
        end
    end

    // A request meeting frame_done applies at once; otherwise it waits in pend_q/tgt_q
    always_comb begin
        req       = ~pend_q & ((state_q == S_MENU) ? (start_btn & ~btn_q) :
                               (state_q == S_GAME) ? finish_any : 1'b0);
        req_tgt   = (state_q == S_MENU) ? S_GAME : S_END;
        cnt_inc   = cnt_q + 1'b1;
        hold_done = (state_q == S_END) && frame_done && (cnt_inc == CW'(END_HOLD_FRAMES));
        state_d   = hold_done           ? S_MENU  :
                    (frame_done && req)    ? req_tgt :
                    (frame_done && pend_q) ? tgt_q   : state_q;
        pend_d    = frame_done ? 1'b0 : (pend_q | req);
        tgt_d     = req ? req_tgt : tgt_q;
    end

    // Outputs are registered from the next state so they track state_q exactly
    always_comb begin
        en_d     = {state_d == S_MENU, state_d == S_GAME, state_d == S_END};
        clear_d  = (state_d == S_GAME) && (state_q != S_GAME);
        winner_d = ((state_d == S_MENU) && (state_q != S_MENU)) ? W_NONE     :
                   (req && (state_q == S_GAME))                 ? det_winner : winner_q;
        cnt_d    = ((state_d == S_END) && (state_q == S_END)) ? (frame_done ? cnt_inc : cnt_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 3'b100;
            clear_q  <= 1'b0;
            winner_q <= W_NONE;
            cnt_q    <= '0;
            btn_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            clear_q  <= clear_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
            btn_q    <= start_btn;
        end
    end

    assign {menu_en, game_en, end_en} = en_q;
    assign game_clear = clear_q;
    assign winner     = winner_q;
endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level screen controller for the LED racer strip: decides which of the menu, game and end screens drives the shared tri-state LED intensity bus by raising exactly one screen enable. It detects the race winner from the four player positions and holds the end screen for a fixed number of strip refreshes before returning to the menu. Screen changes are applied only at strip frame boundaries so a refresh never mixes two screens.

## Interface
- MAX_POS, 109, number of LEDs on the strip; a player at MAX_POS-1 has finished.
- END_HOLD_FRAMES, 150, number of frame_done pulses the end screen stays active; must be ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_btn  in  1  start button level, already synchronized and debounced upstream.
- frame_done  in  1  one-cycle pulse from the LED driver when a strip refresh has finished.
- red_pos, blue_pos, green_pos, yellow_pos  in  $clog2(MAX_POS) each  player positions.
- menu_en  out  1  enable for the menu screen.
- game_en  out  1  enable for the game screen.
- end_en  out  1  enable for the end screen.
- winner  out  3  latched winner code: 0 none, 1 green, 2 red, 3 blue, 4 yellow.
- game_clear  out  1  one-cycle pulse that resets player positions when the game screen is entered.

## Operation
- States: MENU, GAME, END. The enables are a registered one-hot decode of the state; exactly one enable is high at all times after reset.
- Transitions are requested by events and applied only on a frame_done cycle. A request and frame_done in the same cycle apply in that cycle. Otherwise the request is held in a pending flag plus a target register until the next frame_done.
- MENU:
  - A rising edge of start_btn requests GAME.
  - start_btn is compared with a registered copy that resets to 0, so a button held through reset counts as an edge.
  - Further edges while the request is pending are ignored.
- GAME:
  - The first cycle in which any position equals MAX_POS-1 requests END and latches winner.
  - If several players finish at once, priority is green > red > blue > yellow.
  - While the END request is pending, winner is not re-latched.
  - start_btn is ignored in GAME.
- END:
  - Frame counter ($clog2(END_HOLD_FRAMES+1) bits) clears on entry and increments on each frame_done.
  - The frame_done that brings the count to END_HOLD_FRAMES applies the transition to MENU directly, so END spans exactly END_HOLD_FRAMES frame_done pulses.
  - start_btn is ignored in END.
- winner is cleared to 0 when MENU is entered and holds its value through GAME→END and END.
- game_clear is high for exactly the first clock cycle that game_en is high.
- Reset, including mid-frame or mid-pending: state MENU, menu_en=1, game_en=0, end_en=0, winner=0, game_clear=0, pending cleared, frame counter 0, start_btn history 0.

## Timing
- All outputs are registered. An enable change is visible one cycle after the frame_done edge that applies it.
- Start-to-GAME latency: a start edge at cycle t with frame_done at t gives game_en high at t+1. With frame_done at t+k, game_en goes high at t+k+1.
- Finish detection: winner is valid the cycle after the position match. end_en rises the cycle after the next frame_done, or after the same-cycle frame_done.
- frame_done pulses arriving while no request is pending only advance the END counter; they have no other effect.

## Structure
- Shared package screen_pkg holds:
  - state encodings S_MENU, S_GAME, S_END;
  - winner codes W_NONE, W_GREEN, W_RED, W_BLUE, W_YELLOW;
  - the 3-bit winner width.
- Sub-module winner_detect: combinational, parameterized by MAX_POS. It takes the four positions and outputs finish_any and the prioritized winner code, using the same priority order as the end screen colouring.

## Test plan
- Reset release with start_btn low, then start pulse at cycle 10 and frame_done at cycle 14 -> menu_en=1 until cycle 14; game_en=1 and game_clear=1 at cycle 15; game_clear=0 at cycle 16.
- In GAME, red_pos=108 and blue_pos=108 in the same cycle -> winner=2 the next cycle; end_en=1 the cycle after the following frame_done.
- END_HOLD_FRAMES=3, 3 frame_done pulses in END -> menu_en=1 the cycle after the third pulse; winner=0 at the same time.
- start_btn toggled during END and again during GAME -> state unchanged, no game_clear pulse.
- rst_n asserted while a GAME request is pending, then released -> menu_en=1 with no pending transition; the next frame_done causes no change.
- start_btn held high across the reset release -> treated as an edge; GAME is entered at the first frame_done.
